// File: rtl/mw_addsub_seq.sv
// Multi-word add/subtract sequencer.
// Walks two NWORDS*WIDTH-bit operands LSW-first through an external WIDTH-bit
// addsub slice, one word per clock, rippling the carry between words. It
// assembles the wide result and reports the unsigned carry (or no-borrow) out of
// the MSW and the two's-complement overflow of the full-width operation.
module mw_addsub_seq #(
  parameter int WIDTH  = 4,
  parameter int NWORDS = 4
) (
  input  logic                      clk,
  input  logic                      rst_n,
  input  logic                      start,
  input  logic                      sub,
  input  logic [WIDTH*NWORDS-1:0]   op_a,
  input  logic [WIDTH*NWORDS-1:0]   op_b,
  output logic                      busy,
  output logic                      done,
  output logic [WIDTH*NWORDS-1:0]   result,
  output logic                      carry_out,
  output logic                      overflow,
  output logic [WIDTH-1:0]          slice_a,
  output logic [WIDTH-1:0]          slice_b,
  output logic                      slice_cin,
  output logic                      slice_sub,
  input  logic [WIDTH-1:0]          slice_sum,
  input  logic                      slice_cout
);

  localparam int N     = WIDTH * NWORDS;
  localparam int IDX_W = (NWORDS > 1) ? $clog2(NWORDS) : 1;
  localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(NWORDS - 1);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    DONE = 2'd2
  } state_t;

  state_t           state;
  state_t           state_nxt;
  logic             accept;
  logic             last_word;
  logic [IDX_W-1:0] idx;
  logic [N-1:0]     a_q;
  logic [N-1:0]     b_q;
  logic             sub_q;
  logic             carry_q;

  logic [WIDTH-1:0] a_w   [NWORDS];
  logic [WIDTH-1:0] b_w   [NWORDS];
  logic [WIDTH-1:0] res_w [NWORDS];

  // Signed overflow: the effective B sign is inverted for subtraction; overflow
  // happens when both effective operands share a sign the result does not.
  function automatic logic ovf_calc(input logic a_msb, input logic b_msb,
                                    input logic sub_op, input logic r_msb);
    logic bm;
    bm = sub_op ? ~b_msb : b_msb;
    return (a_msb == bm) && (r_msb != a_msb);
  endfunction

  assign busy      = (state != IDLE);
  assign done      = (state == DONE);
  assign last_word = (state == RUN) && (idx == LAST_IDX);

  // Split latched operands into words and pack the stored result words.
  always_comb begin
    for (int i = 0; i < NWORDS; i++) begin
      a_w[i]                   = a_q[i*WIDTH +: WIDTH];
      b_w[i]                   = b_q[i*WIDTH +: WIDTH];
      result[i*WIDTH +: WIDTH] = res_w[i];
    end
  end

  // FSM state register.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state <= IDLE;
    end else begin
      state <= state_nxt;
    end
  end

  // FSM next state; start is only honoured from IDLE.
  always_comb begin
    state_nxt = state;
    accept    = 1'b0;
    case (state)
      IDLE: begin
        if (start) begin
          accept    = 1'b1;
          state_nxt = RUN;
        end
      end
      RUN: begin
        if (idx == LAST_IDX) begin
          state_nxt = DONE;
        end
      end
      DONE:    state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  // Operand latch, word index, ripple carry, result words and final flags.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      a_q       <= '0;
      b_q       <= '0;
      sub_q     <= 1'b0;
      carry_q   <= 1'b0;
      idx       <= '0;
      carry_out <= 1'b0;
      overflow  <= 1'b0;
      for (int i = 0; i < NWORDS; i++) begin
        res_w[i] <= '0;
      end
    end else if (accept) begin
      a_q     <= op_a;
      b_q     <= op_b;
      sub_q   <= sub;
      idx     <= '0;
      // Subtraction is A + ~B + 1, so the first word's carry-in is sub.
      carry_q <= sub;
    end else if (state == RUN) begin
      res_w[idx] <= slice_sum;
      carry_q    <= slice_cout;
      if (idx != LAST_IDX) begin
        idx <= idx + IDX_W'(1);
      end
      if (last_word) begin
        carry_out <= slice_cout;
        overflow  <= ovf_calc(a_q[N-1], b_q[N-1], sub_q, slice_sum[WIDTH-1]);
      end
    end
  end

  // Slice drive: current word while running, quiet zeros otherwise.
  always_comb begin
    slice_a   = '0;
    slice_b   = '0;
    slice_cin = 1'b0;
    slice_sub = 1'b0;
    if (state == RUN) begin
      slice_a   = a_w[idx];
      slice_b   = b_w[idx];
      slice_cin = carry_q;
      slice_sub = sub_q;
    end
  end

endmodule

// File: tb/tb_mw_addsub_seq.sv
// Bench for mw_addsub_seq with a behavioural addsub slice attached.
module tb_mw_addsub_seq;

  localparam int W  = 4;
  localparam int NW = 4;
  localparam int N  = W * NW;

  logic          clk = 1'b0;
  logic          rst_n = 1'b1;
  logic          start = 1'b0;
  logic          sub = 1'b0;
  logic [N-1:0]  op_a = '0;
  logic [N-1:0]  op_b = '0;
  logic          busy, done, carry_out, overflow;
  logic [N-1:0]  result;
  logic [W-1:0]  slice_a, slice_b, slice_sum;
  logic          slice_cin, slice_sub, slice_cout;
  logic [W-1:0]  slice_bsel;

  int checks   = 0;
  int failures = 0;

  always #5 clk = ~clk;

  // Reference addsub slice.
  assign slice_bsel = slice_sub ? ~slice_b : slice_b;
  assign {slice_cout, slice_sum} = {1'b0, slice_a} + {1'b0, slice_bsel} + {{W{1'b0}}, slice_cin};

  mw_addsub_seq #(.WIDTH(W), .NWORDS(NW)) dut (
    .clk(clk), .rst_n(rst_n), .start(start), .sub(sub), .op_a(op_a), .op_b(op_b),
    .busy(busy), .done(done), .result(result), .carry_out(carry_out), .overflow(overflow),
    .slice_a(slice_a), .slice_b(slice_b), .slice_cin(slice_cin), .slice_sub(slice_sub),
    .slice_sum(slice_sum), .slice_cout(slice_cout)
  );

  // Whole-number model of the N-bit operation.
  function automatic void ref_op(input logic [N-1:0] a, input logic [N-1:0] b, input logic s,
                                 output logic [N-1:0] r, output logic co, output logic ov);
    int sa, sb, sr;
    sa = int'($signed(a));
    sb = int'($signed(b));
    sr = s ? (sa - sb) : (sa + sb);
    r  = s ? (a - b) : (a + b);
    co = s ? (a >= b) : ((int'(a) + int'(b)) > 65535);
    ov = (sr > 32767) || (sr < -32768);
  endfunction

  // Issue one operation and wait for done; returns observations only.
  task automatic drive_op(input logic [N-1:0] a, input logic [N-1:0] b, input logic s,
                          output logic [N-1:0] r, output logic co, output logic ov,
                          output int lat, output logic busy_all);
    @(negedge clk);
    op_a = a; op_b = b; sub = s; start = 1'b1;
    @(posedge clk); #1;
    start = 1'b0;
    lat = 0;
    busy_all = busy;
    while (!done && lat < 20) begin
      @(posedge clk); #1;
      lat++;
      busy_all &= busy;
    end
    r  = result;
    co = carry_out;
    ov = overflow;
    @(posedge clk); #1;
  endtask

  task automatic test_reset();
    #2 rst_n = 1'b0;
    #1;
    checks++;
    if ({busy, done, carry_out, overflow, result, slice_a, slice_b, slice_cin, slice_sub} !== '0) begin
      failures++;
      $display("FAIL reset_outputs busy=%b done=%b co=%b ov=%b result=%h sa=%h sb=%h cin=%b ssub=%b required all 0",
               busy, done, carry_out, overflow, result, slice_a, slice_b, slice_cin, slice_sub);
    end
    repeat (2) @(posedge clk);
    @(negedge clk) rst_n = 1'b1;
    @(posedge clk); #1;
    checks++;
    if (busy !== 1'b0 || done !== 1'b0) begin
      failures++;
      $display("FAIL reset_idle busy=%b done=%b required 0 0", busy, done);
    end
  endtask

  task automatic test_directed();
    logic [N-1:0] ta [5] = '{16'h1234, 16'hFFFF, 16'h0005, 16'h7FFF, 16'h8000};
    logic [N-1:0] tb [5] = '{16'h0FCD, 16'h0001, 16'h0009, 16'h0001, 16'h0001};
    logic         ts [5] = '{1'b0, 1'b0, 1'b1, 1'b0, 1'b1};
    logic [N-1:0] er [5] = '{16'h2201, 16'h0000, 16'hFFFC, 16'h8000, 16'h7FFF};
    logic         ec [5] = '{1'b0, 1'b1, 1'b0, 1'b0, 1'b1};
    logic         eo [5] = '{1'b0, 1'b0, 1'b0, 1'b1, 1'b1};
    logic [N-1:0] r;
    logic co, ov, ba;
    int lat;
    for (int i = 0; i < 5; i++) begin
      drive_op(ta[i], tb[i], ts[i], r, co, ov, lat, ba);
      checks++;
      if (lat != NW) begin
        failures++;
        $display("FAIL dir%0d_latency got %0d required %0d", i, lat, NW);
      end
      checks++;
      if (r !== er[i] || co !== ec[i] || ov !== eo[i]) begin
        failures++;
        $display("FAIL dir%0d_result got r=%h co=%b ov=%b required r=%h co=%b ov=%b",
                 i, r, co, ov, er[i], ec[i], eo[i]);
      end
      checks++;
      if (ba !== 1'b1 || busy !== 1'b0 || done !== 1'b0 || result !== er[i]) begin
        failures++;
        $display("FAIL dir%0d_handshake busy_run=%b busy_after=%b done_after=%b held=%h required 1 0 0 %h",
                 i, ba, busy, done, result, er[i]);
      end
    end
  endtask

  task automatic test_random();
    logic [N-1:0] a, b, r, er;
    logic s, co, ov, ec, eo, ba;
    int lat;
    for (int i = 0; i < 40; i++) begin
      a = N'($urandom);
      b = N'($urandom);
      if (i % 8 == 0) b = a;
      s = 1'($urandom_range(0, 1));
      ref_op(a, b, s, er, ec, eo);
      drive_op(a, b, s, r, co, ov, lat, ba);
      checks++;
      if (lat != NW || r !== er || co !== ec || ov !== eo) begin
        failures++;
        $display("FAIL rand%0d a=%h b=%h sub=%b got lat=%0d r=%h co=%b ov=%b required lat=%0d r=%h co=%b ov=%b",
                 i, a, b, s, lat, r, co, ov, NW, er, ec, eo);
      end
    end
  endtask

  task automatic test_start_while_busy();
    logic [N-1:0] er;
    logic ec, eo, ba;
    int lat;
    ref_op(16'h3A5C, 16'h1234, 1'b1, er, ec, eo);
    @(negedge clk);
    op_a = 16'h3A5C; op_b = 16'h1234; sub = 1'b1; start = 1'b1;
    @(posedge clk); #1;
    start = 1'b0;
    ba = busy;
    lat = 0;
    while (!done && lat < 20) begin
      if (lat == 2) begin
        op_a = 16'hFFFF; op_b = 16'hFFFF; sub = 1'b0; start = 1'b1;
      end else begin
        start = 1'b0;
      end
      @(posedge clk); #1;
      lat++;
      ba &= busy;
    end
    start = 1'b0;
    checks++;
    if (lat != NW || ba !== 1'b1 || result !== er || carry_out !== ec || overflow !== eo) begin
      failures++;
      $display("FAIL busy_start lat=%0d busy=%b r=%h co=%b ov=%b required lat=%0d busy=1 r=%h co=%b ov=%b",
               lat, ba, result, carry_out, overflow, NW, er, ec, eo);
    end
    repeat (3) @(posedge clk);
    #1;
    checks++;
    if (busy !== 1'b0 || result !== er) begin
      failures++;
      $display("FAIL busy_start_no_relaunch busy=%b r=%h required 0 %h", busy, result, er);
    end
  endtask

  task automatic test_back_to_back();
    logic [N-1:0] er1, er2;
    logic c1, o1, c2, o2;
    int lat;
    ref_op(16'h4321, 16'h1111, 1'b0, er1, c1, o1);
    ref_op(16'h0100, 16'h0200, 1'b1, er2, c2, o2);
    @(negedge clk);
    op_a = 16'h4321; op_b = 16'h1111; sub = 1'b0; start = 1'b1;
    @(posedge clk); #1;
    lat = 0;
    while (!done && lat < 20) begin
      @(posedge clk); #1;
      lat++;
    end
    checks++;
    if (lat != NW || result !== er1 || carry_out !== c1 || overflow !== o1) begin
      failures++;
      $display("FAIL b2b_first lat=%0d r=%h co=%b ov=%b required lat=%0d r=%h co=%b ov=%b",
               lat, result, carry_out, overflow, NW, er1, c1, o1);
    end
    op_a = 16'h0100; op_b = 16'h0200; sub = 1'b1;
    @(posedge clk); #1;
    checks++;
    if (busy !== 1'b0 || done !== 1'b0) begin
      failures++;
      $display("FAIL b2b_idle busy=%b done=%b required 0 0", busy, done);
    end
    @(posedge clk); #1;
    start = 1'b0;
    checks++;
    if (busy !== 1'b1) begin
      failures++;
      $display("FAIL b2b_accept busy=%b required 1", busy);
    end
    lat = 0;
    while (!done && lat < 20) begin
      @(posedge clk); #1;
      lat++;
    end
    checks++;
    if (lat != NW || result !== er2 || carry_out !== c2 || overflow !== o2) begin
      failures++;
      $display("FAIL b2b_second lat=%0d r=%h co=%b ov=%b required lat=%0d r=%h co=%b ov=%b",
               lat, result, carry_out, overflow, NW, er2, c2, o2);
    end
    @(posedge clk); #1;
  endtask

  task automatic test_reset_mid_run();
    logic [N-1:0] r, er;
    logic co, ov, ec, eo, ba;
    int lat;
    @(negedge clk);
    op_a = 16'hABCD; op_b = 16'h1357; sub = 1'b0; start = 1'b1;
    @(posedge clk); #1;
    start = 1'b0;
    @(posedge clk);
    @(posedge clk);
    #2 rst_n = 1'b0;
    #1;
    checks++;
    if ({busy, done, carry_out, overflow, result, slice_a, slice_b, slice_cin, slice_sub} !== '0) begin
      failures++;
      $display("FAIL midrun_reset busy=%b done=%b co=%b ov=%b result=%h sa=%h sb=%h cin=%b ssub=%b required all 0",
               busy, done, carry_out, overflow, result, slice_a, slice_b, slice_cin, slice_sub);
    end
    @(negedge clk) rst_n = 1'b1;
    ref_op(16'h9000, 16'h9000, 1'b0, er, ec, eo);
    drive_op(16'h9000, 16'h9000, 1'b0, r, co, ov, lat, ba);
    checks++;
    if (lat != NW || r !== er || co !== ec || ov !== eo) begin
      failures++;
      $display("FAIL midrun_recover lat=%0d r=%h co=%b ov=%b required lat=%0d r=%h co=%b ov=%b",
               lat, r, co, ov, NW, er, ec, eo);
    end
  endtask

  initial begin
    test_reset();
    test_directed();
    test_random();
    test_start_while_busy();
    test_back_to_back();
    test_reset_mid_run();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
